// File: rtl/ldm_pkg.sv
// Shared types and constants for the load/store-multiple sequencer.
package ldm_pkg;

   typedef enum logic [1:0] {
      DA = 2'b00,
      IA = 2'b01,
      DB = 2'b10,
      IB = 2'b11
   } pu_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      XFER = 2'b01,
      WB   = 2'b10
   } seq_state_e;

   localparam logic [3:0] PC_REG    = 4'd15;
   localparam logic [1:0] SEL_PC_DP = 2'b11;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
      return c;
   endfunction

endpackage

// File: rtl/lowest_set16.sv
// Combinational priority encoder: index of the lowest set bit of a 16-bit list.
module lowest_set16 (
   input  logic [15:0] list,
   output logic        valid,
   output logic [3:0]  index
);

   always_comb begin
      valid = |list;
      index = '0;
      for (int i = 15; i >= 0; i--) begin
         if (list[i]) index = 4'(i);
      end
   end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Load/store-multiple sequencer: walks a register list lowest-first, one memory word per register,
// feeding regfile write ports 3 (loads) and 2 (base writeback) and redirecting a loaded R15 to the PC.
module ldm_stm_sequencer
   import ldm_pkg::*;
#(
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [15:0]       reglist,
   input  logic [3:0]        base_reg,
   input  logic [31:0]       base_val,
   input  logic [1:0]        pu,
   input  logic              is_load,
   input  logic              wback,
   output logic              busy,
   output logic              done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic [3:0]        str_addr,
   input  logic [31:0]       str_data,
   output logic [3:0]        w_addr3,
   output logic [31:0]       w_data3,
   output logic              w_en3,
   output logic [3:0]        w_addr2,
   output logic [31:0]       w_data2,
   output logic              w_en2,
   output logic              load_pc,
   output logic [1:0]        sel_pc,
   output logic [10:0]       dp_pc
);

   function automatic logic [31:0] first_addr(input logic [1:0] mode, input logic [31:0] base,
                                              input logic [4:0] cnt);
      logic [31:0] c32;
      logic [31:0] res;
      c32 = {27'd0, cnt};
      case (pu_mode_e'(mode))
         IA:      res = base;
         IB:      res = base + 32'd1;
         DA:      res = base - c32 + 32'd1;
         default: res = base - c32;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] last_base(input logic [1:0] mode, input logic [31:0] base,
                                             input logic [4:0] cnt);
      return mode[0] ? base + {27'd0, cnt} : base - {27'd0, cnt};
   endfunction

   seq_state_e  state, state_nxt;
   logic [15:0] remaining;
   logic [15:0] rem_nxt;
   logic [31:0] addr;
   logic [31:0] final_base;
   logic [3:0]  base_reg_q;
   logic        load_q;
   logic        wb_en_q;
   logic        cur_valid;
   logic [3:0]  cur_idx;
   logic        xfer_ack;
   logic [4:0]  start_cnt;

   lowest_set16 u_lowest (
      .list  (remaining),
      .valid (cur_valid),
      .index (cur_idx)
   );

   assign start_cnt = popcount16(reglist);
   assign rem_nxt   = remaining & ~(16'd1 << cur_idx);
   assign xfer_ack  = (state == XFER) && mem_ack;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (reglist != 16'd0) ? XFER : WB;
         XFER:    if (mem_ack && rem_nxt == 16'd0) state_nxt = WB;
         WB:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      done      = (state == WB);
      mem_req   = (state == XFER) && cur_valid;
      mem_we    = mem_req && !load_q;
      mem_wdata = mem_we ? str_data : 32'd0;
      w_en2     = done && wb_en_q;
   end

   assign mem_addr = addr[ADDR_W-1:0];
   assign str_addr = cur_idx;
   assign w_addr2  = base_reg_q;
   assign w_data2  = final_base;
   assign sel_pc   = SEL_PC_DP;

   // Operation capture on start, then per-ack advance; load results land one cycle after their ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         remaining  <= '0;
         addr       <= '0;
         final_base <= '0;
         base_reg_q <= '0;
         load_q     <= 1'b0;
         wb_en_q    <= 1'b0;
         w_en3      <= 1'b0;
         w_addr3    <= '0;
         w_data3    <= '0;
         load_pc    <= 1'b0;
         dp_pc      <= '0;
      end else begin
         w_en3   <= 1'b0;
         load_pc <= 1'b0;
         if (state == IDLE && start) begin
            remaining  <= reglist;
            addr       <= first_addr(pu, base_val, start_cnt);
            final_base <= last_base(pu, base_val, start_cnt);
            base_reg_q <= base_reg;
            load_q     <= is_load;
            // A base register reloaded from memory must keep the loaded value.
            wb_en_q    <= wback && (reglist != 16'd0) && !(is_load && reglist[base_reg]);
         end
         if (xfer_ack) begin
            remaining <= rem_nxt;
            addr      <= addr + 32'd1;
            if (load_q) begin
               if (cur_idx == PC_REG) begin
                  load_pc <= 1'b1;
                  dp_pc   <= mem_rdata[10:0];
               end else begin
                  w_en3   <= 1'b1;
                  w_addr3 <= cur_idx;
                  w_data3 <= mem_rdata;
               end
            end
         end
      end
   end

endmodule
